// File: rtl/dct_pkg.sv
// dct_pkg: shared constants and helpers for the sequential N-point 2D DCT.
//  - m32_t / M32 : HEVC 32x32 forward-transform matrix, signed 8-bit entries,
//                  M32[k][n]; the NxN matrix is rows k*(32/N) of it.
//  - clog2_n     : log2 of a power-of-two transform size.
//  - shift1/2    : row-pass and column-pass rounding shifts.
//  - state_t     : control FSM states.
package dct_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ROW  = 2'd1,
    S_COL  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  typedef logic [31:0][31:0][7:0] m32_t;

  function automatic int clog2_n(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 6; i++) if ((1 << i) == v) r = i;
    return r;
  endfunction

  function automatic int shift1(input int n, input int bd);
    return clog2_n(n) + bd - 9;
  endfunction

  function automatic int shift2(input int n);
    return clog2_n(n) + 6;
  endfunction

  // Magnitude of the HEVC coefficient for angle m*pi/64, m in 0..31.
  function automatic int base_coef(input int m);
    case (m)
      0, 16:    return 64;
      1, 2, 3:  return 90;
      4:  return 89;  5:  return 88;  6:  return 87;  7:  return 85;
      8:  return 83;  9:  return 82;  10: return 80;  11: return 78;
      12: return 75;  13: return 73;  14: return 70;  15: return 67;
      17: return 61;  18: return 57;  19: return 54;  20: return 50;
      21: return 46;  22: return 43;  23: return 38;  24: return 36;
      25: return 31;  26: return 25;  27: return 22;  28: return 18;
      29: return 13;  30: return 9;   31: return 4;
      default: return 0;
    endcase
  endfunction

  // The HEVC matrix keeps the cosine symmetries exactly: entry (k,n) is the
  // coefficient for angle k*(2n+1)*pi/64 folded into the first quadrant.
  // Row 0 is the flat 64 row.
  function automatic m32_t build_m32();
    m32_t t;
    int   m, v;
    t = '0;
    for (int k = 0; k < 32; k++) begin
      for (int n = 0; n < 32; n++) begin
        m = (k * (2 * n + 1)) % 128;
        if (m > 64) m = 128 - m;
        if (k == 0)      v = 64;
        else if (m < 32) v = base_coef(m);
        else             v = -base_coef(64 - m);
        t[k][n] = 8'(v);
      end
    end
    return t;
  endfunction

  localparam m32_t M32 = build_m32();

endpackage

// File: rtl/dct_dot_n.sv
// dct_dot_n: combinational N-term signed dot product with HEVC rounding.
//  a   in  [N] s16   data operands
//  c   in  [N] s8    matrix coefficients
//  sh  in  5         rounding shift (>=1)
//  res out s16       (sum(a*c) + 2^(sh-1)) >>> sh, reduced to 16 bits
// Reduction: wraps to the low 16 bits by default; with DCT_SAT_EN defined
// it saturates to [-32768, 32767].
module dct_dot_n
#(
  parameter int N = 4
) (
  input  logic [N-1:0][15:0] a,
  input  logic [N-1:0][7:0]  c,
  input  logic [4:0]         sh,
  output logic [15:0]        res
);

  logic signed [23:0] prod [N];

  for (genvar g = 0; g < N; g++) begin : g_lane
    logic signed [23:0] ae, ce;
    assign ae      = {{8{a[g][15]}}, a[g]};
    assign ce      = {{16{c[g][7]}}, c[g]};
    assign prod[g] = ae * ce;
  end

  // 32 products of 16x8 bits stay well inside 32 bits.
  logic signed [31:0] acc, rnd, sum;

  always_comb begin
    acc = '0;
    for (int n = 0; n < N; n++) acc = acc + {{8{prod[n][23]}}, prod[n]};
  end

  assign rnd = 32'sd1 <<< (sh - 5'd1);
  assign sum = acc + rnd;

`ifdef DCT_SAT_EN
  logic signed [31:0] shd;
  assign shd = sum >>> sh;
  always_comb begin
    if (shd > 32'sd32767)       res = 16'h7fff;
    else if (shd < -32'sd32768) res = 16'h8000;
    else                        res = shd[15:0];
  end
`else
  assign res = 16'(sum >>> sh);
`endif

endmodule

// File: rtl/dct_n_2d_seq_core.sv
// dct_n_2d_seq_core: sequential HEVC forward 2D DCT of an NxN s16 block,
// one coefficient per cycle through a single shared dct_dot_n.
//  clk    in   1         rising-edge clock
//  reset  in   1         asynchronous active-high reset
//  start  in   1         rising edge in IDLE/DONE launches a transform
//  x      in   [N][N]    input block x[row][col], captured on accept
//  y      out  [N][N]    coefficients y[vert][horiz], registered
//  done   out  1         result complete; held until next accepted start
// Params: N (4/8/16/32), BIT_DEPTH. Macro DCT_SAT_EN selects saturation
// instead of 16-bit wrap for intermediate and output values.
module dct_n_2d_seq_core
  import dct_pkg::*;
#(
  parameter int N         = 4,
  parameter int BIT_DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [N-1:0][N-1:0][15:0] x,
  output logic [N-1:0][N-1:0][15:0] y,
  output logic                      done
);

  localparam int            LN   = clog2_n(N);
  localparam int            S1   = shift1(N, BIT_DEPTH);
  localparam int            S2   = shift2(N);
  localparam logic [LN-1:0] LAST = LN'(N - 1);

  if (!(N == 4 || N == 8 || N == 16 || N == 32)) begin : g_bad_n
    $error("dct_n_2d_seq_core: N must be 4, 8, 16 or 32");
  end
  if (S1 < 1) begin : g_bad_s1
    $error("dct_n_2d_seq_core: BIT_DEPTH too small, first shift < 1");
  end

  state_t                    state, next_state;
  logic                      start_q, rise, accept, issue, last, drain;
  logic [LN-1:0]             k_cnt, o_cnt;
  logic [N-1:0][N-1:0][15:0] xb, tmp;
  logic [N-1:0][15:0]        a;
  logic [N-1:0][7:0]         c;
  logic [4:0]                sh, krow;
  logic [15:0]               dot_res;

  // One register stage between the dot product and the tmp/y write port.
  logic [15:0]               res_q;
  logic                      res_vld, res_col;
  logic [LN-1:0]             res_o, res_k;

  assign rise = start & ~start_q;
  assign last = (k_cnt == LAST) && (o_cnt == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // COL keeps one extra drain cycle so DONE coincides with the last y write.
  always_comb begin
    next_state = state;
    issue      = 1'b0;
    accept     = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (rise) begin
          accept     = 1'b1;
          next_state = S_ROW;
        end
      end
      S_ROW: begin
        issue = 1'b1;
        if (last) next_state = S_COL;
      end
      S_COL: begin
        issue = ~drain;
        if (drain) next_state = S_DONE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // k_cnt is the output frequency (fastest); o_cnt is the row in ROW and
  // the column in COL.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k_cnt <= '0;
      o_cnt <= '0;
      drain <= 1'b0;
    end else if (accept) begin
      k_cnt <= '0;
      o_cnt <= '0;
      drain <= 1'b0;
    end else if (issue) begin
      if (k_cnt == LAST) begin
        k_cnt <= '0;
        if (o_cnt == LAST) begin
          o_cnt <= '0;
          drain <= (state == S_COL);
        end else begin
          o_cnt <= o_cnt + 1'b1;
        end
      end else begin
        k_cnt <= k_cnt + 1'b1;
      end
    end
  end

  // Operand muxing: ROW dots a row of xb, COL dots a column of tmp.
  // Last tmp write lands one cycle into COL, but COL reads that column last.
  always_comb begin
    krow = 5'(k_cnt) << (5 - LN);
    sh   = (state == S_ROW) ? 5'(S1) : 5'(S2);
    for (int n = 0; n < N; n++) begin
      c[n] = M32[krow][n];
      a[n] = (state == S_ROW) ? xb[o_cnt][n] : tmp[n][o_cnt];
    end
  end

  dct_dot_n #(.N(N)) u_dot (
    .a   (a),
    .c   (c),
    .sh  (sh),
    .res (dot_res)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_q <= 1'b0;
      done    <= 1'b0;
      xb      <= '0;
      tmp     <= '0;
      y       <= '0;
      res_q   <= '0;
      res_vld <= 1'b0;
      res_col <= 1'b0;
      res_o   <= '0;
      res_k   <= '0;
    end else begin
      start_q <= start;
      done    <= (next_state == S_DONE);
      if (accept) xb <= x;
      res_vld <= issue;
      res_col <= (state == S_COL);
      res_o   <= o_cnt;
      res_k   <= k_cnt;
      res_q   <= dot_res;
      if (res_vld) begin
        if (res_col) y[res_k][res_o]   <= res_q;
        else         tmp[res_o][res_k] <= res_q;
      end
    end
  end

endmodule

// File: tb/tb_dct_n_2d_seq_core.sv
// Bench for dct_n_2d_seq_core: N=4 table vectors, random blocks against a
// matrix-product reference, handshake corner cases, plus one N=32 instance.
module tb_dct_n_2d_seq_core;

  localparam int N   = 4;
  localparam int BD  = 8;
  localparam int S1  = 2 + BD - 9;
  localparam int S2  = 2 + 6;
  localparam int LAT = 2 * N * N + 1;

  typedef int blk_t [4][4];
  typedef struct {
    string      name;
    blk_t       xin;
    blk_t       ey;
    logic [15:0] mask;
  } vec_t;

  localparam int T4 [4][4] = '{'{64, 64, 64, 64}, '{83, 36, -36, -83},
                               '{64, -64, -64, 64}, '{36, -83, 83, -36}};

  logic                      clk = 1'b0;
  logic                      reset, start, done, start32, done32;
  logic [N-1:0][N-1:0][15:0] x, y;
  logic [31:0][31:0][15:0]   x32, y32;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dct_n_2d_seq_core #(.N(4), .BIT_DEPTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .x(x), .y(y), .done(done)
  );

  dct_n_2d_seq_core #(.N(32), .BIT_DEPTH(8)) dut32 (
    .clk(clk), .reset(reset), .start(start32), .x(x32), .y(y32), .done(done32)
  );

  function automatic int fit16(input longint v);
`ifdef DCT_SAT_EN
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return int'(v);
`else
    logic signed [15:0] t;
    t = v[15:0];
    return int'(t);
`endif
  endfunction

  // Y = T * (X * T^T) with rounding shifts after each product.
  function automatic blk_t model(input blk_t xin);
    blk_t   t, o;
    longint acc;
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++) begin
        acc = 0;
        for (int n = 0; n < 4; n++) acc += T4[k][n] * xin[i][n];
        t[i][k] = fit16((acc + (1 << (S1 - 1))) >>> S1);
      end
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < 4; j++) begin
        acc = 0;
        for (int i = 0; i < 4; i++) acc += T4[k][i] * t[i][j];
        o[k][j] = fit16((acc + (1 << (S2 - 1))) >>> S2);
      end
    return o;
  endfunction

  function automatic blk_t fillv(input int v);
    blk_t b;
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) b[i][j] = v;
    return b;
  endfunction

  function automatic blk_t rnd_blk(input bit wide);
    blk_t b;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        b[i][j] = wide ? int'($signed(16'($urandom())))
                       : int'($urandom_range(510)) - 255;
    return b;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cmp_blk(input string name, input blk_t act, input blk_t exp,
                         input logic [15:0] mask);
    int bi, bj;
    bi = -1; bj = -1;
    for (int i = 3; i >= 0; i--)
      for (int j = 3; j >= 0; j--)
        if (mask[i*4+j] && act[i][j] != exp[i][j]) begin bi = i; bj = j; end
    total++;
    if (bi >= 0) begin
      bad++;
      $display("FAIL %s: y[%0d][%0d] got %0d expected %0d",
               name, bi, bj, act[bi][bj], exp[bi][bj]);
    end
  endtask

  task automatic read_y(output blk_t r);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) r[i][j] = int'($signed(y[i][j]));
  endtask

  // Launch one block; x is scrambled after the accept edge. glitch>0 pulses
  // start again on that cycle. lat = edges from accept to done (-1 timeout).
  task automatic run(input blk_t xin, input int hold, input int glitch,
                     output int lat, output int d1);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) x[i][j] = 16'(xin[i][j]);
    start = 1'b1;
    lat = -1;
    d1  = -1;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      @(negedge clk);
      if (cyc == 1) d1 = int'(done);
      if (cyc == 2)
        for (int i = 0; i < 4; i++)
          for (int j = 0; j < 4; j++) x[i][j] = 16'($urandom());
      if (cyc == hold) start = 1'b0;
      if (glitch > 0 && cyc == glitch) start = 1'b1;
      if (glitch > 0 && cyc == glitch + 1) start = 1'b0;
      if (done) begin
        lat = cyc - 1;
        break;
      end
    end
    start = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vt [6];
    blk_t got, exp, b, ck;
    int   lat, d1, nz, seen;

    ck = fillv(0);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) ck[i][j] = ((i + j) % 2 == 0) ? 100 : -100;

    vt[0].name = "zero";    vt[0].xin = fillv(0);    vt[0].ey = fillv(0);
    vt[0].mask = 16'hffff;
    vt[1].name = "all100";  vt[1].xin = fillv(100);  vt[1].ey = fillv(0);
    vt[1].ey[0][0] = 12800; vt[1].mask = 16'hffff;
    vt[2].name = "all255";  vt[2].xin = fillv(255);  vt[2].ey = fillv(0);
    vt[2].ey[0][0] = 32640; vt[2].mask = 16'hffff;
    vt[3].name = "impulse"; vt[3].xin = fillv(0);    vt[3].xin[0][0] = 1000;
    vt[3].ey = fillv(0);
    vt[3].ey[0][0] = 8000;  vt[3].ey[1][0] = 10375;
    vt[3].ey[2][0] = 8000;  vt[3].ey[3][0] = 4500;
    vt[3].mask = 16'h1111;  // column 0 is independent of tmp reduction
    vt[4].name = "checker"; vt[4].xin = ck;          vt[4].ey = fillv(0);
    vt[4].ey[1][1] = 1726;  vt[4].ey[1][3] = 4370;
    vt[4].ey[3][1] = 4370;  vt[4].ey[3][3] = 11063;  vt[4].mask = 16'hffff;
    vt[5].name = "allm255"; vt[5].xin = fillv(-255); vt[5].ey = fillv(0);
    vt[5].ey[0][0] = -32640; vt[5].mask = 16'hffff;

    reset = 1'b1; start = 1'b0; start32 = 1'b0; x = '0; x32 = '0;
    repeat (2) @(negedge clk);
    chk("reset_done_held", int'(done), 0);
    reset = 1'b0;
    @(negedge clk);
    read_y(got);
    cmp_blk("reset_y", got, fillv(0), 16'hffff);
    chk("reset_done", int'(done), 0);
    chk("reset_done32", int'(done32), 0);

    // N=32, flat input
    for (int i = 0; i < 32; i++) for (int j = 0; j < 32; j++) x32[i][j] = 16'd255;
    start32 = 1'b1;
    lat = -1;
    for (int cyc = 1; cyc <= 2300; cyc++) begin
      @(negedge clk);
      if (cyc == 1) start32 = 1'b0;
      if (done32) begin lat = cyc - 1; break; end
    end
    chk("n32_latency", lat, 2049);
    chk("n32_y00", int'($signed(y32[0][0])), 32640);
    nz = 0;
    for (int i = 0; i < 32; i++)
      for (int j = 0; j < 32; j++)
        if (!(i == 0 && j == 0) && y32[i][j] != 16'd0) nz++;
    chk("n32_nonzero_rest", nz, 0);

    // Table vectors
    for (int v = 0; v < 6; v++) begin
      run(vt[v].xin, 1, 0, lat, d1);
      chk($sformatf("%s_latency", vt[v].name), lat, LAT);
      if (v > 0) chk($sformatf("%s_done_fall", vt[v].name), d1, 0);
      read_y(got);
      cmp_blk($sformatf("%s_const", vt[v].name), got, vt[v].ey, vt[v].mask);
      cmp_blk($sformatf("%s_model", vt[v].name), got, model(vt[v].xin), 16'hffff);
    end

    // y stays put while done is high
    exp = model(vt[5].xin);
    repeat (6) @(negedge clk);
    read_y(got);
    chk("done_still_high", int'(done), 1);
    cmp_blk("y_stable", got, exp, 16'hffff);

    // Random blocks
    for (int r = 0; r < 10; r++) begin
      b = rnd_blk(r >= 7);
      run(b, 1, 0, lat, d1);
      chk($sformatf("rand%0d_latency", r), lat, LAT);
      read_y(got);
      cmp_blk($sformatf("rand%0d_model", r), got, model(b), 16'hffff);
    end

    // start held 3 cycles: one run only
    b = rnd_blk(1'b0);
    run(b, 3, 0, lat, d1);
    chk("hold3_latency", lat, LAT);
    read_y(got);
    cmp_blk("hold3_model", got, model(b), 16'hffff);

    // start edge during ROW, then during COL: ignored
    b = rnd_blk(1'b0);
    run(b, 1, 5, lat, d1);
    chk("glitch_row_latency", lat, LAT);
    read_y(got);
    cmp_blk("glitch_row_model", got, model(b), 16'hffff);
    b = rnd_blk(1'b0);
    run(b, 1, 22, lat, d1);
    chk("glitch_col_latency", lat, LAT);
    read_y(got);
    cmp_blk("glitch_col_model", got, model(b), 16'hffff);

    // Reset during COL aborts the run
    b = fillv(200);
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) x[i][j] = 16'(b[i][j]);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (21) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_done", int'(done), 0);
    read_y(got);
    cmp_blk("abort_y", got, fillv(0), 16'hffff);
    seen = 0;
    for (int cyc = 0; cyc < 45; cyc++) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("abort_no_done", seen, 0);

    // Recovery after abort
    b = rnd_blk(1'b0);
    run(b, 1, 0, lat, d1);
    chk("recover_latency", lat, LAT);
    read_y(got);
    cmp_blk("recover_model", got, model(b), 16'hffff);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
